// File: rtl/alu_exec_if.sv
// alu_exec_if: operand/decode inputs and result handshake between the EX-stage control and the ALU.
interface alu_exec_if #(
    parameter int XLEN = 64
);
    logic [1:0]      ALUOp;
    logic [3:0]      Funct;
    logic            MExt;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            in_valid;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Result;
    logic            Zero;
    logic            Illegal;
    logic            busy;

    modport master (
        output ALUOp, Funct, MExt, A, B, in_valid, out_ready,
        input  in_ready, out_valid, Result, Zero, Illegal, busy
    );

    modport slave (
        input  ALUOp, Funct, MExt, A, B, in_valid, out_ready,
        output in_ready, out_valid, Result, Zero, Illegal, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with merged ALUOp/Funct decode, registered single-cycle results
// and iterative shift-add MUL / restoring DIVU/REMU behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input logic       clk,
    input logic       reset,
    input logic       flush,
    alu_exec_if.slave io
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_DIVU, OP_REMU, OP_ILL
    } op_t;

    state_t          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic            rem_q, rem_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    op_t             op;
    logic [3:0]      key;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  sh;
    logic            slot_free;
    logic            in_ready;
    logic            accept;
    logic            last;
    logic [XLEN:0]   r_sh;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] acc_step;
    logic [XLEN-1:0] opa_step;
    logic [XLEN-1:0] opb_step;
    logic [XLEN-1:0] fin;

    // I-type ignores funct7[5] except to pick SRAI over SRLI
    always_comb begin
        key = (io.ALUOp == 2'b11 && io.Funct[2:0] != 3'b101) ? {1'b0, io.Funct[2:0]} : io.Funct;
        op  = OP_ILL;
        if (io.ALUOp == 2'b00)
            op = OP_ADD;
        else if (io.ALUOp == 2'b01)
            op = OP_SUB;
        else if (io.ALUOp == 2'b10 && io.MExt)
            case (key)
                4'b0000: op = OP_MUL;
                4'b0101: op = OP_DIVU;
                4'b0111: op = OP_REMU;
                default: op = OP_ILL;
            endcase
        else
            case (key)
                4'b0000: op = OP_ADD;
                4'b1000: op = OP_SUB;
                4'b0001: op = OP_SLL;
                4'b0010: op = OP_SLT;
                4'b0011: op = OP_SLTU;
                4'b0100: op = OP_XOR;
                4'b0101: op = OP_SRL;
                4'b1101: op = OP_SRA;
                4'b0110: op = OP_OR;
                4'b0111: op = OP_AND;
                default: op = OP_ILL;
            endcase
    end

    assign sh = io.B[SHW-1:0];

    // DIVU/REMU only reach this path with B==0; MUL and illegal ops yield zero
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = io.A + io.B;
            OP_SUB:  alu_res = io.A - io.B;
            OP_SLL:  alu_res = io.A << sh;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(io.A) < $signed(io.B)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, io.A < io.B};
            OP_XOR:  alu_res = io.A ^ io.B;
            OP_SRL:  alu_res = io.A >> sh;
            OP_SRA:  alu_res = XLEN'($signed(io.A) >>> sh);
            OP_OR:   alu_res = io.A | io.B;
            OP_AND:  alu_res = io.A & io.B;
            OP_DIVU: alu_res = '1;
            OP_REMU: alu_res = io.A;
            default: alu_res = '0;
        endcase
    end

    // MUL: acc += mcand when multiplier lsb set. DIV: opa holds dividend shifting into quotient.
    always_comb begin
        r_sh     = {acc_q, opa_q[XLEN-1]};
        diff     = r_sh - {1'b0, opb_q};
        ge       = !diff[XLEN];
        acc_step = (state_q == S_MUL) ? acc_q + (opb_q[0] ? opa_q : '0)
                                      : (ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0]);
        opa_step = (state_q == S_MUL) ? opa_q << 1 : {opa_q[XLEN-2:0], ge};
        opb_step = (state_q == S_MUL) ? opb_q >> 1 : opb_q;
        fin      = (state_q == S_MUL || rem_q) ? acc_step : opa_step;
    end

    assign slot_free = !out_valid_q || io.out_ready;
    assign in_ready  = (state_q == S_IDLE) && slot_free;
    assign accept    = io.in_valid && in_ready;
    assign last      = (state_q != S_IDLE) && (cnt_q == SHW'(XLEN-1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q && !io.out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        if (accept) begin
            if (op == OP_MUL || ((op == OP_DIVU || op == OP_REMU) && io.B != '0)) begin
                state_d = (op == OP_MUL) ? S_MUL : S_DIV;
                cnt_d   = '0;
                acc_d   = '0;
                opa_d   = io.A;
                opb_d   = io.B;
                rem_d   = (op == OP_REMU);
            end else begin
                out_valid_d = 1'b1;
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                illegal_d   = (op == OP_ILL);
            end
        end else if (last && slot_free) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b1;
            result_d    = fin;
            zero_d      = (fin == '0);
            illegal_d   = 1'b0;
        end else if (state_q != S_IDLE && !last) begin
            cnt_d = cnt_q + SHW'(1);
            acc_d = acc_step;
            opa_d = opa_step;
            opb_d = opb_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rem_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.Result    = result_q;
    assign io.Zero      = zero_q;
    assign io.Illegal   = illegal_q;
    assign io.busy      = (state_q != S_IDLE);
endmodule
